opb_register_bank_ppc2simulink: RTL and testbench

OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

---
 rtl/opb_register_bank_ppc2simulink.sv | 155 +++++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: shadow registers written over OPB, copied to the user-side
// active registers on a CTRL commit. Build option OPB_REGBANK_READBACK_EN adds register readback.
`timescale 1ns/1ps
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01181100,
  parameter logic [31:0] C_HIGHADDR   = 32'h011811FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0] user_data_out,
  output logic                    user_load
);

  if (C_NUM_REGS < 1 || C_NUM_REGS > 16 || C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 ||
      C_FAMILY == "") begin : g_bad_cfg
    $error("opb_register_bank_ppc2simulink: illegal parameter set");
  end

  localparam logic [29:0] ACTIVE_WORD = 30'd16;
  localparam logic [29:0] CTRL_WORD   = 30'd32;
  localparam logic [29:0] STATUS_WORD = 30'd33;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_e;

  state_e      state_r, state_next_s;
  logic [31:0] abus_s, off_s, wdata_s, rdata_s;
  logic [29:0] word_s;
  logic [3:0]  be_s;
  logic        hit_s, commit_s, wr_ack_s, unused_s;

  logic        ack_r, req_rnw_r, user_load_r;
  logic [29:0] req_word_r;
  logic [3:0]  req_be_r;
  logic [31:0] req_data_r, sl_dbus_r;
  logic [15:0] commit_cnt_r;
  logic [31:0] shadow_r [C_NUM_REGS];
  logic [31:0] active_r [C_NUM_REGS];

  // Big-endian OPB vectors assigned numerically: be_s[0] is the byte holding DBus[24:31].
  assign abus_s   = OPB_ABus;
  assign wdata_s  = OPB_DBus;
  assign be_s     = OPB_BE;
  assign off_s    = abus_s - C_BASEADDR;
  assign word_s   = off_s[31:2];
  assign hit_s    = OPB_select && (abus_s >= C_BASEADDR) && (abus_s <= C_HIGHADDR);
  assign unused_s = ^{OPB_seqAddr, off_s[1:0]};

  assign wr_ack_s = (state_r == ST_ACK) && !req_rnw_r;
  assign commit_s = wr_ack_s && (req_word_r == CTRL_WORD) && req_be_r[0] && req_data_r[0];

  // Next-state logic: every hit gets exactly one ACK cycle, then back to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) state_next_s = ST_ACK;
        else       state_next_s = ST_IDLE;
      end
      ST_ACK:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Read data selection for the address presented in the hit cycle.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (word_s == STATUS_WORD) begin
      rdata_s = {16'h0000, commit_cnt_r};
    end else begin
`ifdef OPB_REGBANK_READBACK_EN
      for (int k = 0; k < C_NUM_REGS; k++) begin
        rdata_s = (word_s == 30'(k)) ? shadow_r[k] : rdata_s;
        rdata_s = (word_s == ACTIVE_WORD + 30'(k)) ? active_r[k] : rdata_s;
      end
`else
      rdata_s = 32'h0000_0000;
`endif
    end
  end

  // Bus-side state: FSM, request capture and registered slave outputs.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_r    <= ST_IDLE;
      ack_r      <= 1'b0;
      sl_dbus_r  <= 32'h0000_0000;
      req_rnw_r  <= 1'b0;
      req_word_r <= 30'd0;
      req_be_r   <= 4'h0;
      req_data_r <= 32'h0000_0000;
    end else begin
      state_r   <= state_next_s;
      ack_r     <= (state_next_s == ST_ACK);
      sl_dbus_r <= (state_r == ST_IDLE && hit_s && OPB_RNW) ? rdata_s : 32'h0000_0000;
      if (state_r == ST_IDLE && hit_s) begin
        req_rnw_r  <= OPB_RNW;
        req_word_r <= word_s;
        req_be_r   <= be_s;
        req_data_r <= wdata_s;
      end
    end
  end

  // Register file: byte-masked shadow writes, commit to active, commit counter and load strobe.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int k = 0; k < C_NUM_REGS; k++) begin
        shadow_r[k] <= 32'h0000_0000;
        active_r[k] <= 32'h0000_0000;
      end
      commit_cnt_r <= 16'h0000;
      user_load_r  <= 1'b0;
    end else begin
      user_load_r <= commit_s;
      if (commit_s) begin
        for (int k = 0; k < C_NUM_REGS; k++) active_r[k] <= shadow_r[k];
        commit_cnt_r <= commit_cnt_r + 16'd1;
      end
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (wr_ack_s && req_word_r == 30'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (req_be_r[b]) shadow_r[k][8*b +: 8] <= req_data_r[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_user
    assign user_data_out[32*k +: 32] = active_r[k];
  end

  assign Sl_DBus    = sl_dbus_r;
  assign Sl_xferAck = ack_r;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign user_load  = user_load_r;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink: directed steps plus random
// register traffic checked against an array-based model of the register bank.
`timescale 1ns/1ps
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h01181100;
  localparam logic [31:0] HIGH = 32'h011811FF;
  localparam int          NREG = 4;

  logic OPB_Clk = 1'b0;
  logic OPB_Rst = 1'b1;
  logic [0:31] OPB_ABus = 32'h0;
  logic [0:3]  OPB_BE = 4'h0;
  logic [0:31] OPB_DBus = 32'h0;
  logic OPB_RNW = 1'b0, OPB_select = 1'b0, OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [NREG*32-1:0] user_data_out;
  logic user_load;

  opb_register_bank_ppc2simulink #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_REGS(NREG)) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup), .user_data_out(user_data_out), .user_load(user_load));

  always #5 OPB_Clk = ~OPB_Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_shadow [NREG];
  logic [31:0] m_active [NREG];
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NREG; k++) begin
      m_shadow[k] = 32'h0;
      m_active[k] = 32'h0;
    end
    m_cnt = 16'h0;
  endfunction

  // be[b] enables value byte b (b=0 is the least significant byte, i.e. OPB BE[3]).
  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) m = m + (32'h0000_00FF << (8 * b));
    return m;
  endfunction

  function automatic bit model_write(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
    logic [31:0] mask = byte_mask(be);
    if (off < 32'(4 * NREG) && off[1:0] == 2'b00) begin
      m_shadow[off / 4] = (m_shadow[off / 4] & ~mask) | (data & mask);
      return 1'b0;
    end
    if (off == 32'h80 && data[0] && be[0]) begin
      for (int k = 0; k < NREG; k++) m_active[k] = m_shadow[k];
      m_cnt = m_cnt + 16'd1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] off);
    if (off == 32'h84) return {16'h0, m_cnt};
`ifdef OPB_REGBANK_READBACK_EN
    if (off < 32'(4 * NREG)) return m_shadow[off / 4];
    if (off >= 32'h40 && off < 32'h40 + 32'(4 * NREG)) return m_active[(off - 32'h40) / 4];
`endif
    return 32'h0;
  endfunction

  function automatic logic [127:0] model_out();
    logic [127:0] r = 128'h0;
    for (int k = 0; k < NREG; k++) r = r | (128'(m_active[k]) << (32 * k));
    return r;
  endfunction

  // One OPB transfer; lat = cycles from select to ack, or -1 if no ack within 8 cycles.
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, output logic [31:0] rd, output int lat);
    int c;
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_RNW = rnw; OPB_ABus = addr; OPB_DBus = data; OPB_BE = be;
    lat = -1; rd = 32'h0; c = 0;
    while (lat < 0 && c < 8) begin
      c++;
      @(posedge OPB_Clk);
      @(negedge OPB_Clk);
      if (Sl_xferAck === 1'b1) begin
        lat = c;
        rd = Sl_DBus;
      end
    end
    OPB_select = 1'b0; OPB_RNW = 1'b0; OPB_ABus = 32'h0; OPB_DBus = 32'h0; OPB_BE = 4'h0;
  endtask

  task automatic do_op(input string tag, input logic rnw, input logic [31:0] off,
                       input logic [31:0] data, input logic [3:0] be);
    logic [31:0] rd, exp_rd;
    int lat;
    bit com;
    exp_rd = model_read(off);
    xfer(rnw, BASE + off, data, be, rd, lat);
    chk({tag, " latency"}, 128'(lat), 128'(1));
    com = 1'b0;
    if (rnw) chk({tag, " rdata"}, 128'(rd), 128'(exp_rd));
    else begin
      chk({tag, " wr Sl_DBus"}, 128'(rd), 128'(0));
      com = model_write(off, data, be);
    end
    @(negedge OPB_Clk);
    chk({tag, " user_load"}, 128'(user_load), 128'(com));
    chk({tag, " user_data_out"}, 128'(user_data_out), model_out());
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    model_reset();

    // Reset state
    repeat (3) @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    chk("rst ack", 128'(Sl_xferAck), 128'(0));
    chk("rst dbus", 128'(Sl_DBus), 128'(0));
    chk("rst ties", 128'({Sl_errAck, Sl_retry, Sl_toutSup}), 128'(0));
    chk("rst user_load", 128'(user_load), 128'(0));
    chk("rst user_data_out", 128'(user_data_out), 128'(0));
    OPB_Rst = 1'b0;

    // Shadow write invisible until commit, then commit
    do_op("wr0", 1'b0, 32'h0, 32'hDEADBEEF, 4'b1111);
    chk("wr0 active0 still zero", 128'(user_data_out[31:0]), 128'(0));
    do_op("commit1", 1'b0, 32'h80, 32'h00000001, 4'b1111);
    chk("commit1 active0", 128'(user_data_out[31:0]), 128'(32'hDEADBEEF));
    @(negedge OPB_Clk);
    chk("commit1 load one cycle", 128'(user_load), 128'(0));
    do_op("status1", 1'b1, 32'h84, 32'h0, 4'b1111);
    chk("status1 model", 128'(model_read(32'h84)), 128'(32'h1));

    // Byte-enable write
    do_op("wr1 be0100", 1'b0, 32'h4, 32'h11223344, 4'b0100);
`ifdef OPB_REGBANK_READBACK_EN
    do_op("rd shadow1", 1'b1, 32'h4, 32'h0, 4'b1111);
`endif
    do_op("commit2", 1'b0, 32'h80, 32'h00000001, 4'b0001);
    chk("shadow1 bytes", 128'(user_data_out[63:32]), 128'(32'h00220000));

    // CTRL/unmapped behaviour
    do_op("ctrl nocommit", 1'b0, 32'h80, 32'hFFFFFFFE, 4'b1111);
    do_op("ctrl be off", 1'b0, 32'h80, 32'h00000001, 4'b1110);
    do_op("ctrl rd", 1'b1, 32'h80, 32'h0, 4'b1111);
    do_op("unmapped wr", 1'b0, 32'h7C, 32'hCAFEF00D, 4'b1111);
    do_op("unmapped rd", 1'b1, 32'h7C, 32'h0, 4'b1111);

    // Random traffic against the model
    for (int i = 0; i < 48; i++) begin
      logic [31:0] d;
      logic [3:0] be;
      int k;
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      k = $urandom_range(0, NREG - 1);
      case ($urandom_range(0, 5))
        0, 1, 2: do_op("rnd wr", 1'b0, 32'(4 * k), d, be);
        3:       do_op("rnd commit", 1'b0, 32'h80, d | 32'h1, be | 4'h1);
        4:       do_op("rnd rd", 1'b1, 32'(4 * $urandom_range(0, 63)), 32'h0, 4'hF);
        default: do_op("rnd wr any", 1'b0, 32'(4 * $urandom_range(0, 63)), d, be);
      endcase
    end
    do_op("rnd status", 1'b1, 32'h84, 32'h0, 4'hF);

    // Held select: commits on consecutive transfers, ack every second cycle
    do_op("burst prep", 1'b0, 32'h8, 32'h5A5A5A5A, 4'hF);
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_seqAddr = 1'b1;
    OPB_ABus = BASE + 32'h80; OPB_DBus = 32'h1; OPB_BE = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge OPB_Clk);
      @(negedge OPB_Clk);
      chk("burst ack", 128'(Sl_xferAck), 128'(i % 2 == 0));
      chk("burst load", 128'(user_load), 128'(i % 2 == 1));
    end
    OPB_select = 1'b0; OPB_seqAddr = 1'b0; OPB_ABus = 32'h0; OPB_DBus = 32'h0; OPB_BE = 4'h0;
    for (int i = 0; i < 3; i++) void'(model_write(32'h80, 32'h1, 4'hF));
    @(negedge OPB_Clk);
    chk("burst user_data_out", 128'(user_data_out), model_out());
    do_op("burst status", 1'b1, 32'h84, 32'h0, 4'hF);

    // Counter wrap: preload as if 65535 commits had happened
    @(negedge OPB_Clk);
    force dut.commit_cnt_r = 16'hFFFF;
    @(posedge OPB_Clk);
    #1 release dut.commit_cnt_r;
    m_cnt = 16'hFFFF;
    do_op("status ffff", 1'b1, 32'h84, 32'h0, 4'hF);
    do_op("wrap commit", 1'b0, 32'h80, 32'h1, 4'hF);
    do_op("status wrap", 1'b1, 32'h84, 32'h0, 4'hF);
    chk("status wrap model", 128'(model_read(32'h84)), 128'(0));

    // Reset during the ACK of a commit
    do_op("pre-rst wr", 1'b0, 32'h0, 32'h12345678, 4'hF);
    @(negedge OPB_Clk);
    OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_ABus = BASE + 32'h80; OPB_DBus = 32'h1; OPB_BE = 4'hF;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    chk("rst-in-ack ack", 128'(Sl_xferAck), 128'(1));
    OPB_Rst = 1'b1;
    OPB_select = 1'b0;
    @(posedge OPB_Clk);
    @(negedge OPB_Clk);
    chk("rst-in-ack load", 128'(user_load), 128'(0));
    chk("rst-in-ack out", 128'(user_data_out), 128'(0));
    chk("rst-in-ack ack low", 128'(Sl_xferAck), 128'(0));
    OPB_Rst = 1'b0;
    model_reset();
    @(negedge OPB_Clk);
    chk("post-rst load", 128'(user_load), 128'(0));
    chk("post-rst idle", 128'(Sl_xferAck), 128'(0));
    do_op("post-rst status", 1'b1, 32'h84, 32'h0, 4'hF);

    // Out-of-range accesses get no ack
    xfer(1'b1, HIGH + 32'h1, 32'h0, 4'hF, rd, lat);
    chk("above high no ack", 128'(lat > 0), 128'(0));
    xfer(1'b1, BASE - 32'h4, 32'h0, 4'hF, rd, lat);
    chk("below base no ack", 128'(lat > 0), 128'(0));
    xfer(1'b1, HIGH - 32'h3, 32'h0, 4'hF, rd, lat);
    chk("top word acked", 128'(lat), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
